triangle_monitor: RTL

Receive-side checker for the triangle sample stream produced by the team's triangle generator. Consumes one N-bit sample per cycle while `ena` is high, tracks slope direction, and flags peaks and troughs. Flags any sample that breaks the triangle sequence and optionally measures the period in samples. Sits at the input of a DAC/PWM test path, or in bench loop-back as a self-check on the generator.

---
 rtl/triangle_pkg.sv | 14 +
 rtl/triangle_period_meter.sv | 41 ++++
 rtl/triangle_monitor.sv | 95 +++++++++
 3 files changed

// File: rtl/triangle_pkg.sv
// triangle_pkg: state encoding and sample-range helper shared by the triangle generator and monitor.
package triangle_pkg;

    typedef enum logic [1:0] {
        TRI_ACQUIRE = 2'd0,
        TRI_UP      = 2'd1,
        TRI_DOWN    = 2'd2
    } tri_state_t;

    function automatic int unsigned tri_max(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/triangle_period_meter.sv
// triangle_period_meter: counts accepted samples between repeated troughs and reports the trough-to-trough period.
module triangle_period_meter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         acc,
    input  logic         trough_ev,
    input  logic         clr,
    output logic [N+1:0] period,
    output logic         period_valid
);
    localparam logic [N+1:0] ONE = (N+2)'(1);

    logic [N+1:0] pcnt;
    logic         pcnt_run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt         <= '0;
            pcnt_run     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (clr) begin
                pcnt_run <= 1'b0;
            end else if (trough_ev) begin
                pcnt_run <= 1'b1;
                pcnt     <= '0;
                if (pcnt_run) begin
                    period       <= pcnt + ONE;
                    period_valid <= 1'b1;
                end
            end else if (acc && pcnt_run && pcnt != '1) begin
                pcnt <= pcnt + ONE;
            end
        end
    end

endmodule

// File: rtl/triangle_monitor.sv
// triangle_monitor: checks a triangle sample stream, flags peaks, troughs and sequence errors.
// Define TRIANGLE_MONITOR_PERIOD_EN to add trough-to-trough period measurement.
module triangle_monitor
    import triangle_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] in,
    output logic [1:0]   dir,
    output logic         locked,
    output logic         peak,
    output logic         trough,
    output logic         err,
    output logic         err_sticky,
    output logic [N+1:0] period,
    output logic         period_valid
);
    localparam logic [N-1:0] MAX = N'(tri_max(N));
    localparam logic [N-1:0] ONE = N'(1);

    tri_state_t   state;
    tri_state_t   nxt;
    logic [N-1:0] last;
    logic         have_last;
    logic         up_ok;
    logic         dn_ok;
    logic         pk_ok;
    logic         tr_ok;
    logic         peak_ev;
    logic         trough_ev;
    logic         bad;

    // Guards on MAX/0 keep the +1/-1 steps from wrapping around the range.
    always_comb begin
        up_ok     = last != MAX && in == last + ONE;
        dn_ok     = last != '0 && in == last - ONE;
        pk_ok     = last == MAX && in == MAX;
        tr_ok     = last == '0 && in == '0;
        peak_ev   = ena && state == TRI_UP && pk_ok;
        trough_ev = ena && state == TRI_DOWN && tr_ok;
        bad       = ena && ((state == TRI_UP && !(up_ok || pk_ok)) ||
                            (state == TRI_DOWN && !(dn_ok || tr_ok)));
        nxt       = state == TRI_ACQUIRE ?
                        (!have_last ? TRI_ACQUIRE : up_ok ? TRI_UP : dn_ok ? TRI_DOWN : TRI_ACQUIRE) :
                    bad ? TRI_ACQUIRE : peak_ev ? TRI_DOWN : trough_ev ? TRI_UP : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= TRI_ACQUIRE;
            last       <= '0;
            have_last  <= 1'b0;
            peak       <= 1'b0;
            trough     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            peak       <= peak_ev;
            trough     <= trough_ev;
            err        <= bad;
            err_sticky <= err_sticky | bad;
            if (ena) begin
                state     <= nxt;
                last      <= in;
                have_last <= 1'b1;
            end
        end
    end

    assign dir    = state;
    assign locked = state != TRI_ACQUIRE;

`ifdef TRIANGLE_MONITOR_PERIOD_EN
    logic acc;

    assign acc = ena && state != TRI_ACQUIRE && !bad;

    triangle_period_meter #(.N(N)) u_meter (
        .clk          (clk),
        .rst          (rst),
        .acc          (acc),
        .trough_ev    (trough_ev),
        .clr          (bad),
        .period       (period),
        .period_valid (period_valid)
    );
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule
